dram_req_queue: RTL and testbench

- Request buffer and ordering stage between the GPU core's DRAM request port and the single-beat AXI4 master FSM.
- Replaces the "addr != 0 means read" inference with an explicit valid/ready request handshake.
- Absorbs bursts of framebuffer and texture requests in a FIFO and bounds the number of outstanding transactions.
- Returns read data and write acks in order.

---
 rtl/dram_req_pkg.sv | 25 ++
 rtl/sync_fifo_sa.sv | 66 ++++++
 rtl/dram_req_queue.sv | 184 ++++++++++++++++++
 tb/tb_dram_req_queue.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_req_pkg.sv
// Shared types and helpers for the DRAM request queue: request/response
// records and the FIFO pointer-width function.
package dram_req_pkg;

    // Record field widths; the queue's ADDR_WIDTH/DATA_WIDTH default to these.
    localparam int REQ_ADDR_W = 32;
    localparam int REQ_DATA_W = 32;

    typedef struct packed {
        logic                  we;
        logic [REQ_ADDR_W-1:0] addr;
        logic [REQ_DATA_W-1:0] wdata;
    } dram_req_t;

    typedef struct packed {
        logic                  we;
        logic [REQ_DATA_W-1:0] rdata;
        logic                  err;
    } dram_rsp_t;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sync_fifo_sa.sv
// Show-ahead synchronous FIFO: the head entry is visible on o_data while
// not empty. Pushes when full and pops when empty are ignored.
module sync_fifo_sa
    import dram_req_pkg::*;
#(
    parameter int  WIDTH = 8,
    parameter int  DEPTH = 16,
    localparam int PTR_W = ptr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic [PTR_W:0]   o_count,
    output logic             o_full,
    output logic             o_empty
);

    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CNT_FULL);
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_count = r_count;
    // Zero the head while empty so the command bus reads 0 after reset.
    assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/dram_req_queue.sv
// Request queue between the GPU core DRAM port and the single-beat AXI master:
// buffers requests, caps outstanding transactions, returns responses in order.
// Optional statistics counters are enabled with `define DRAM_REQ_STATS_EN.
module dram_req_queue
    import dram_req_pkg::*;
#(
    parameter int ADDR_WIDTH = REQ_ADDR_W,
    parameter int DATA_WIDTH = REQ_DATA_W,
    parameter int DEPTH      = 16,
    parameter int MAX_OUT    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_we,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic [DATA_WIDTH-1:0] i_req_wdata,
    output logic                  o_cmd_valid,
    input  logic                  i_cmd_ready,
    output logic                  o_cmd_we,
    output logic [ADDR_WIDTH-1:0] o_cmd_addr,
    output logic [DATA_WIDTH-1:0] o_cmd_wdata,
    input  logic                  i_rsp_valid,
    input  logic                  i_rsp_we,
    input  logic [DATA_WIDTH-1:0] i_rsp_rdata,
    input  logic                  i_rsp_err,
    output logic                  o_rd_valid,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_wr_ack,
    output logic                  o_err,
    input  logic                  i_err_clr,
    output logic                  o_idle
`ifdef DRAM_REQ_STATS_EN
    ,
    output logic [31:0]           o_stat_rd_cnt,
    output logic [31:0]           o_stat_wr_cnt,
    output logic [31:0]           o_stat_stall_cnt
`endif
);

    localparam int             PTR_W     = ptr_width(DEPTH);
    localparam logic [3:0]     MAX_OUT_C = 4'(MAX_OUT);
    localparam logic [3:0]     OUT_ONE   = 4'd1;
    localparam logic [PTR_W:0] CNT_ONE   = (PTR_W+1)'(1);

    dram_req_t      w_req_in;
    dram_req_t      w_head;
    dram_rsp_t      w_rsp;
    logic [PTR_W:0] w_count;
    logic [PTR_W:0] w_cnt_next;
    logic           w_full;
    logic           w_empty;
    logic           w_push;
    logic           w_pop;
    logic           w_cmd_valid;
    logic           w_spurious;
    logic           w_rsp_ok;
    logic [3:0]     w_out_next;

    logic [3:0]            r_outstanding;
    logic                  r_rd_valid;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_wr_ack;
    logic                  r_err;
    logic                  r_idle;

    always_comb begin
        w_req_in       = '0;
        w_req_in.we    = i_req_we;
        w_req_in.addr  = i_req_addr;
        w_req_in.wdata = i_req_wdata;
        w_rsp          = '0;
        w_rsp.we       = i_rsp_we;
        w_rsp.rdata    = i_rsp_rdata;
        w_rsp.err      = i_rsp_err;
    end

    sync_fifo_sa #(
        .WIDTH ($bits(dram_req_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_req_in),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign o_req_ready = !w_full;
    assign w_push      = i_req_valid && !w_full;
    assign w_cmd_valid = !w_empty && (r_outstanding < MAX_OUT_C);
    assign w_pop       = w_cmd_valid && i_cmd_ready;
    assign o_cmd_valid = w_cmd_valid;
    assign o_cmd_we    = w_head.we;
    assign o_cmd_addr  = w_head.addr;
    assign o_cmd_wdata = w_head.wdata;

    // A response with nothing outstanding is spurious: flagged, never counted.
    assign w_spurious = i_rsp_valid && (r_outstanding == '0);
    assign w_rsp_ok   = i_rsp_valid && !w_spurious;

    always_comb begin
        w_out_next = r_outstanding;
        if (w_pop && !w_rsp_ok) begin
            w_out_next = r_outstanding + OUT_ONE;
        end else if (!w_pop && w_rsp_ok) begin
            w_out_next = r_outstanding - OUT_ONE;
        end
    end

    always_comb begin
        w_cnt_next = w_count;
        if (w_push && !w_pop) begin
            w_cnt_next = w_count + CNT_ONE;
        end else if (!w_push && w_pop) begin
            w_cnt_next = w_count - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_outstanding <= '0;
            r_rd_valid    <= 1'b0;
            r_rd_data     <= '0;
            r_wr_ack      <= 1'b0;
            r_err         <= 1'b0;
            r_idle        <= 1'b1;
        end else begin
            r_outstanding <= w_out_next;
            r_rd_valid    <= w_rsp_ok && !w_rsp.we;
            r_wr_ack      <= w_rsp_ok && w_rsp.we;
            if (w_rsp_ok && !w_rsp.we) begin
                r_rd_data <= w_rsp.rdata;
            end
            // Setting takes priority over a same-cycle clear.
            if ((i_rsp_valid && w_rsp.err) || w_spurious) begin
                r_err <= 1'b1;
            end else if (i_err_clr) begin
                r_err <= 1'b0;
            end
            r_idle <= (w_cnt_next == '0) && (w_out_next == '0);
        end
    end

    assign o_rd_valid = r_rd_valid;
    assign o_rd_data  = r_rd_data;
    assign o_wr_ack   = r_wr_ack;
    assign o_err      = r_err;
    assign o_idle     = r_idle;

`ifdef DRAM_REQ_STATS_EN
    logic [31:0] r_stat_rd_cnt;
    logic [31:0] r_stat_wr_cnt;
    logic [31:0] r_stat_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_err_clr) begin
            r_stat_rd_cnt    <= '0;
            r_stat_wr_cnt    <= '0;
            r_stat_stall_cnt <= '0;
        end else begin
            if (w_pop && !w_head.we) begin
                r_stat_rd_cnt <= r_stat_rd_cnt + 32'd1;
            end
            if (w_pop && w_head.we) begin
                r_stat_wr_cnt <= r_stat_wr_cnt + 32'd1;
            end
            if (!w_empty && !w_cmd_valid) begin
                r_stat_stall_cnt <= r_stat_stall_cnt + 32'd1;
            end
        end
    end

    assign o_stat_rd_cnt    = r_stat_rd_cnt;
    assign o_stat_wr_cnt    = r_stat_wr_cnt;
    assign o_stat_stall_cnt = r_stat_stall_cnt;
`endif

endmodule

// File: tb/tb_dram_req_queue.sv
// Bench for dram_req_queue: directed scenarios plus random traffic, all
// checked every cycle against a queue-based reference model.
module tb_dram_req_queue;

    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int DEPTH   = 16;
    localparam int MAX_OUT = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req_valid, i_req_we, i_cmd_ready;
    logic [AW-1:0] i_req_addr;
    logic [DW-1:0] i_req_wdata, i_rsp_rdata;
    logic          i_rsp_valid, i_rsp_we, i_rsp_err, i_err_clr;
    logic          o_req_ready, o_cmd_valid, o_cmd_we;
    logic [AW-1:0] o_cmd_addr;
    logic [DW-1:0] o_cmd_wdata, o_rd_data;
    logic          o_rd_valid, o_wr_ack, o_err, o_idle;
`ifdef DRAM_REQ_STATS_EN
    logic [31:0]   o_stat_rd_cnt, o_stat_wr_cnt, o_stat_stall_cnt;
`endif

    always #5 clk = ~clk;

    dram_req_queue #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .MAX_OUT    (MAX_OUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_req_valid (i_req_valid),
        .o_req_ready (o_req_ready),
        .i_req_we    (i_req_we),
        .i_req_addr  (i_req_addr),
        .i_req_wdata (i_req_wdata),
        .o_cmd_valid (o_cmd_valid),
        .i_cmd_ready (i_cmd_ready),
        .o_cmd_we    (o_cmd_we),
        .o_cmd_addr  (o_cmd_addr),
        .o_cmd_wdata (o_cmd_wdata),
        .i_rsp_valid (i_rsp_valid),
        .i_rsp_we    (i_rsp_we),
        .i_rsp_rdata (i_rsp_rdata),
        .i_rsp_err   (i_rsp_err),
        .o_rd_valid  (o_rd_valid),
        .o_rd_data   (o_rd_data),
        .o_wr_ack    (o_wr_ack),
        .o_err       (o_err),
        .i_err_clr   (i_err_clr),
        .o_idle      (o_idle)
`ifdef DRAM_REQ_STATS_EN
        ,
        .o_stat_rd_cnt    (o_stat_rd_cnt),
        .o_stat_wr_cnt    (o_stat_wr_cnt),
        .o_stat_stall_cnt (o_stat_stall_cnt)
`endif
    );

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    // Reference model: queued requests, outstanding count, expected registered outputs.
    req_t        m_q[$];
    int          m_out;
    bit          exp_rd_valid, exp_wr_ack, exp_err, exp_idle;
    logic [31:0] exp_rd_data;

    int n_checks = 0;
    int n_fail   = 0;
    int obs_pops = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        i_req_valid = 1'b0; i_req_we = 1'b0; i_req_addr = '0; i_req_wdata = '0;
        i_cmd_ready = 1'b0; i_rsp_valid = 1'b0; i_rsp_we = 1'b0;
        i_rsp_rdata = '0; i_rsp_err = 1'b0; i_err_clr = 1'b0;
    endtask

    // Called at a negedge with inputs already driven: check, advance model, cross one edge.
    task automatic step();
        int cnt;
        bit m_cv, push, pop, spur;
        req_t r;
        cnt  = m_q.size();
        m_cv = (cnt > 0) && (m_out < MAX_OUT);
        check_eq("req_ready", o_req_ready, (cnt < DEPTH));
        check_eq("cmd_valid", o_cmd_valid, m_cv);
        if (m_cv) begin
            check_eq("cmd_we", o_cmd_we, m_q[0].we);
            check_eq("cmd_addr", o_cmd_addr, m_q[0].addr);
            check_eq("cmd_wdata", o_cmd_wdata, m_q[0].wdata);
        end
        check_eq("rd_valid", o_rd_valid, exp_rd_valid);
        if (exp_rd_valid) check_eq("rd_data", o_rd_data, exp_rd_data);
        check_eq("wr_ack", o_wr_ack, exp_wr_ack);
        check_eq("err", o_err, exp_err);
        check_eq("idle", o_idle, exp_idle);
        if (o_cmd_valid && i_cmd_ready) obs_pops++;

        push = i_req_valid && (cnt < DEPTH);
        pop  = m_cv && i_cmd_ready;
        spur = i_rsp_valid && (m_out == 0);
        exp_rd_valid = i_rsp_valid && !i_rsp_we && !spur;
        exp_wr_ack   = i_rsp_valid && i_rsp_we && !spur;
        if (exp_rd_valid) exp_rd_data = i_rsp_rdata;
        if (i_rsp_valid && (i_rsp_err || spur)) exp_err = 1'b1;
        else if (i_err_clr) exp_err = 1'b0;
        if (pop) void'(m_q.pop_front());
        if (push) begin
            r.we = i_req_we; r.addr = i_req_addr; r.wdata = i_req_wdata;
            m_q.push_back(r);
        end
        m_out    = m_out + (pop ? 1 : 0) - ((i_rsp_valid && !spur) ? 1 : 0);
        exp_idle = (m_q.size() == 0) && (m_out == 0);
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_q.delete();
        m_out = 0; exp_rd_valid = 0; exp_wr_ack = 0; exp_err = 0; exp_idle = 1;
        exp_rd_data = '0;
        check_eq("rst_idle", o_idle, 1);
        check_eq("rst_cmd_valid", o_cmd_valid, 0);
        check_eq("rst_req_ready", o_req_ready, 1);
        check_eq("rst_rd_valid", o_rd_valid, 0);
        check_eq("rst_wr_ack", o_wr_ack, 0);
        check_eq("rst_err", o_err, 0);
        check_eq("rst_cmd_addr", o_cmd_addr, 0);
        check_eq("rst_rd_data", o_rd_data, 0);
    endtask

    task automatic push_req(input bit we, input logic [31:0] addr, input logic [31:0] data);
        i_req_valid = 1'b1; i_req_we = we; i_req_addr = addr; i_req_wdata = data;
        step();
        i_req_valid = 1'b0;
    endtask

    // Pop everything and answer everything, bounded.
    task automatic drain();
        for (int k = 0; k < 400; k++) begin
            if (m_q.size() == 0 && m_out == 0) break;
            idle_inputs();
            i_cmd_ready = 1'b1;
            i_rsp_valid = (m_out > 0) && ($urandom_range(0, 1) == 1);
            i_rsp_we    = $urandom_range(0, 1) == 1;
            i_rsp_rdata = $urandom;
            step();
        end
        idle_inputs();
        step();
        check_eq("drain_idle", o_idle, 1);
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        do_reset();

        // Single read, answered with 0xDEADBEEF.
        push_req(1'b0, 32'h1000, 32'h0);
        check_eq("single_cmd_valid", o_cmd_valid, 1);
        check_eq("single_cmd_addr", o_cmd_addr, 32'h1000);
        i_cmd_ready = 1'b1; step(); i_cmd_ready = 1'b0;
        i_rsp_valid = 1'b1; i_rsp_we = 1'b0; i_rsp_rdata = 32'hDEADBEEF;
        step();
        idle_inputs();
        check_eq("single_rd_valid", o_rd_valid, 1);
        check_eq("single_rd_data", o_rd_data, 32'hDEADBEEF);
        step();
        check_eq("single_idle", o_idle, 1);

        // Fill with 16 writes while stalled; the 17th is held off.
        for (int i = 0; i < 17; i++) push_req(1'b1, 32'h2000 + 32'(i * 4), 32'hA500 + 32'(i));
        check_eq("full_ready", o_req_ready, 0);
        drain();

        // Outstanding cap: 6 reads, 4 issue, one response releases the 5th.
        do_reset();
        for (int i = 0; i < 6; i++) push_req(1'b0, 32'h3000 + 32'(i * 4), 32'h0);
        i_cmd_ready = 1'b1;
        obs_pops = 0;
        for (int i = 0; i < 8; i++) step();
        check_eq("maxout_pops", obs_pops, 4);
        i_rsp_valid = 1'b1; i_rsp_we = 1'b0; i_rsp_rdata = 32'h1234_5678;
        step();
        i_rsp_valid = 1'b0;
        check_eq("reissue_valid", o_cmd_valid, 1);
        obs_pops = 0;
        step();
        check_eq("reissue_pops", obs_pops, 1);
        drain();

        // Simultaneous pop+response at outstanding 2, push+pop at count 5.
        do_reset();
        for (int i = 0; i < 7; i++) push_req(1'b0, 32'h4000 + 32'(i * 4), 32'h0);
        i_cmd_ready = 1'b1;
        step(); step();
        i_req_valid = 1'b1; i_req_we = 1'b1; i_req_addr = 32'h4100; i_req_wdata = 32'h77;
        i_rsp_valid = 1'b1; i_rsp_we = 1'b0; i_rsp_rdata = 32'h55;
        step();
        idle_inputs();
        i_cmd_ready = 1'b1;
        obs_pops = 0;
        for (int i = 0; i < 4; i++) step();
        check_eq("out2_pops", obs_pops, 2);
        drain();

        // Error flag: errored write response, clear, spurious response.
        do_reset();
        push_req(1'b1, 32'h5000, 32'hCAFE);
        i_cmd_ready = 1'b1; step(); i_cmd_ready = 1'b0;
        i_rsp_valid = 1'b1; i_rsp_we = 1'b1; i_rsp_err = 1'b1;
        step();
        idle_inputs();
        check_eq("err_wr_ack", o_wr_ack, 1);
        check_eq("err_set", o_err, 1);
        i_err_clr = 1'b1; step(); i_err_clr = 1'b0;
        check_eq("err_clr", o_err, 0);
        i_rsp_valid = 1'b1; i_rsp_we = 1'b0; i_rsp_rdata = 32'h99;
        step();
        idle_inputs();
        check_eq("spur_err", o_err, 1);
        check_eq("spur_no_rd", o_rd_valid, 0);
        check_eq("spur_no_ack", o_wr_ack, 0);
        step();

        // Reset with 3 queued and 2 outstanding.
        do_reset();
        for (int i = 0; i < 5; i++) push_req(1'b1, 32'h6000 + 32'(i * 4), 32'(i));
        i_cmd_ready = 1'b1; step(); step();
        do_reset();
        step();

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            idle_inputs();
            i_req_valid = $urandom_range(0, 99) < 60;
            i_req_we    = $urandom_range(0, 1) == 1;
            i_req_addr  = $urandom & 32'hFFFF_FFFC;
            i_req_wdata = $urandom;
            i_cmd_ready = $urandom_range(0, 99) < 50;
            if (m_out > 0) i_rsp_valid = $urandom_range(0, 99) < 40;
            else           i_rsp_valid = $urandom_range(0, 99) < 2;
            i_rsp_we    = $urandom_range(0, 1) == 1;
            i_rsp_rdata = $urandom;
            i_rsp_err   = $urandom_range(0, 99) < 5;
            i_err_clr   = $urandom_range(0, 99) < 5;
            step();
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
